// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths and writeback-source encodings.
// The MEM/WB register and the control unit use the same encodings.
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        REGSRC_ALU  = 2'b00,
        REGSRC_MEM  = 2'b01,
        REGSRC_LUI  = 2'b10,
        REGSRC_SEXT = 2'b11
    } regsrc_e;

endpackage

// File: rtl/wb_src_mux.sv
// Writeback source select and immediate forming.
// Purely combinational; the forwarding unit reuses it.
module wb_src_mux
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic [1:0]        reg_src,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [15:0]       immediate,
    output logic [DATA_W-1:0] wb_data
);

    always_comb begin
        wb_data = alu_out;
        case (reg_src)
            REGSRC_ALU:  wb_data = alu_out;
            REGSRC_MEM:  wb_data = mem_data;
            REGSRC_LUI:  wb_data = DATA_W'({immediate, 16'h0000});
            REGSRC_SEXT: wb_data = {{(DATA_W-16){immediate[15]}}, immediate};
            default:     wb_data = alu_out;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: source select, 32-entry register file with write-through
// read ports, and current/previous writeback info for the forwarding unit.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W    = cpu_pkg::DATA_W,
    parameter int ADDR_W    = cpu_pkg::ADDR_W,
    parameter int NUM_REGS  = cpu_pkg::NUM_REGS,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        wb_in_RegSrc,
    input  logic              wb_in_RegWrite,
    input  logic [DATA_W-1:0] wb_in_ALUOut_EXEC,
    input  logic [DATA_W-1:0] wb_in_Mem_dataOut,
    input  logic [ADDR_W-1:0] wb_in_write_reg_dest,
    input  logic [15:0]       wb_in_immediate,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              wb_fwd_valid,
    output logic [ADDR_W-1:0] wb_fwd_dest,
    output logic [DATA_W-1:0] wb_fwd_data,
    output logic              wb_prev_valid,
    output logic [ADDR_W-1:0] wb_prev_dest,
    output logic [DATA_W-1:0] wb_prev_data,
    output logic [31:0]       wb_write_count
);

    logic [DATA_W-1:0] wb_data;
    logic              eff;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              prev_valid_q, prev_valid_d;
    logic [ADDR_W-1:0] prev_dest_q, prev_dest_d;
    logic [DATA_W-1:0] prev_data_q, prev_data_d;
    logic [31:0]       write_count_q, write_count_d;

    wb_src_mux #(.DATA_W(DATA_W)) u_src_mux (
        .reg_src   (wb_in_RegSrc),
        .alu_out   (wb_in_ALUOut_EXEC),
        .mem_data  (wb_in_Mem_dataOut),
        .immediate (wb_in_immediate),
        .wb_data   (wb_data)
    );

    // Writes to r0 and writes during reset are both non-events.
    assign eff = wb_in_RegWrite && (wb_in_write_reg_dest != '0) && !rst;

    always_comb begin
        regs_d        = regs_q;
        prev_valid_d  = eff;
        prev_dest_d   = prev_dest_q;
        prev_data_d   = prev_data_q;
        write_count_d = write_count_q;
        if (eff) begin
            regs_d[wb_in_write_reg_dest] = wb_data;
            prev_dest_d                  = wb_in_write_reg_dest;
            prev_data_d                  = wb_data;
            if (write_count_q != 32'hFFFF_FFFF)
                write_count_d = write_count_q + 32'd1;
        end
    end

    // Entry 0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
            prev_valid_q  <= 1'b0;
            prev_dest_q   <= '0;
            prev_data_q   <= '0;
            write_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            prev_valid_q  <= prev_valid_d;
            prev_dest_q   <= prev_dest_d;
            prev_data_q   <= prev_data_d;
            write_count_q <= write_count_d;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 :
                       (BYPASS_EN && eff && (rd_addr_a == wb_in_write_reg_dest)) ? wb_data :
                       regs_q[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 :
                       (BYPASS_EN && eff && (rd_addr_b == wb_in_write_reg_dest)) ? wb_data :
                       regs_q[rd_addr_b];

    assign wb_fwd_valid   = eff;
    assign wb_fwd_dest    = wb_in_write_reg_dest;
    assign wb_fwd_data    = wb_data;
    assign wb_prev_valid  = prev_valid_q;
    assign wb_prev_dest   = prev_dest_q;
    assign wb_prev_data   = prev_data_q;
    assign wb_write_count = write_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a bypassing and a non-bypassing instance
// share stimulus; expected values go through a queue and are popped at check time.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  src = 2'b00;
    logic        we = 1'b0;
    logic [31:0] alu = '0;
    logic [31:0] mem = '0;
    logic [4:0]  dest = '0;
    logic [15:0] imm = '0;
    logic [4:0]  ra = '0;
    logic [4:0]  rb = '0;

    logic [31:0] rda, rdb, fwd_data, prev_data, cnt;
    logic        fwd_valid, prev_valid;
    logic [4:0]  fwd_dest, prev_dest;

    logic [31:0] nb_rda, nb_rdb, nb_fwd_data, nb_prev_data, nb_cnt;
    logic        nb_fwd_valid, nb_prev_valid;
    logic [4:0]  nb_fwd_dest, nb_prev_dest;

    logic [31:0] exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_regfile #(.BYPASS_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .wb_in_RegSrc(src), .wb_in_RegWrite(we),
        .wb_in_ALUOut_EXEC(alu), .wb_in_Mem_dataOut(mem),
        .wb_in_write_reg_dest(dest), .wb_in_immediate(imm),
        .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(rda), .rd_data_b(rdb),
        .wb_fwd_valid(fwd_valid), .wb_fwd_dest(fwd_dest), .wb_fwd_data(fwd_data),
        .wb_prev_valid(prev_valid), .wb_prev_dest(prev_dest), .wb_prev_data(prev_data),
        .wb_write_count(cnt)
    );

    wb_regfile #(.BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .wb_in_RegSrc(src), .wb_in_RegWrite(we),
        .wb_in_ALUOut_EXEC(alu), .wb_in_Mem_dataOut(mem),
        .wb_in_write_reg_dest(dest), .wb_in_immediate(imm),
        .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(nb_rda), .rd_data_b(nb_rdb),
        .wb_fwd_valid(nb_fwd_valid), .wb_fwd_dest(nb_fwd_dest), .wb_fwd_data(nb_fwd_data),
        .wb_prev_valid(nb_prev_valid), .wb_prev_dest(nb_prev_dest), .wb_prev_data(nb_prev_data),
        .wb_write_count(nb_cnt)
    );

    function automatic logic [31:0] model_sel(input logic [1:0] s, input logic [31:0] a,
                                              input logic [31:0] m, input logic [15:0] i);
        case (s)
            2'b00:   return a;
            2'b01:   return m;
            2'b10:   return {i, 16'h0000};
            default: return {{16{i[15]}}, i};
        endcase
    endfunction

    task automatic expect_v(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; the rising edge commits them.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic [1:0] s, input logic [4:0] d,
                         input logic [31:0] a, input logic [31:0] m, input logic [15:0] i);
        we = w; src = s; dest = d; alu = a; mem = m; imm = i;
        #1;
    endtask

    initial begin
        logic [31:0] v;
        @(negedge clk);

        // Reset with a pending write to r5
        rst = 1'b1;
        drive(1'b1, 2'b00, 5'd5, 32'hCAFE_0005, '0, '0);
        expect_v(32'd0); chk("rst_fwd_valid", {31'd0, fwd_valid});
        tick(); tick();
        rst = 1'b0;
        drive(1'b0, 2'b00, 5'd5, 32'hCAFE_0005, '0, '0);
        for (int k = 0; k < 32; k++) begin
            ra = 5'(k); rb = 5'(31 - k); #1;
            expect_v(32'd0); chk($sformatf("rst_rd_a[%0d]", k), rda);
            expect_v(32'd0); chk($sformatf("rst_rd_b[%0d]", 31 - k), rdb);
        end
        expect_v(32'd0); chk("rst_count", cnt);
        expect_v(32'd0); chk("rst_prev_valid", {31'd0, prev_valid});

        // Source select, back to back into r3
        ra = 5'd3; rb = 5'd3;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), 5'd3, 32'h1234_5678, 32'hDEAD_BEEF, 16'h8001);
            v = model_sel(2'(k), 32'h1234_5678, 32'hDEAD_BEEF, 16'h8001);
            expect_v(v); chk($sformatf("src%0d_fwd_data", k), fwd_data);
            expect_v(v); chk($sformatf("src%0d_bypass_rd", k), rda);
            tick();
            we = 1'b0; #1;
            expect_v(v); chk($sformatf("src%0d_stored_rd", k), nb_rda);
        end
        expect_v(32'd4); chk("src_count", cnt);

        // r0 protection
        ra = 5'd0;
        drive(1'b1, 2'b00, 5'd0, 32'hFFFF_FFFF, '0, '0);
        expect_v(32'd0); chk("r0_rd", rda);
        expect_v(32'd0); chk("r0_fwd_valid", {31'd0, fwd_valid});
        tick();
        drive(1'b0, 2'b00, 5'd0, '0, '0, '0);
        expect_v(32'd4); chk("r0_count", cnt);
        expect_v(32'd0); chk("r0_prev_valid", {31'd0, prev_valid});

        // Bypass vs stored read of r7
        drive(1'b1, 2'b00, 5'd7, 32'h11, '0, '0);
        tick();
        ra = 5'd7; rb = 5'd7;
        drive(1'b1, 2'b00, 5'd7, 32'h22, '0, '0);
        expect_v(32'h22); chk("byp_rd_a", rda);
        expect_v(32'h22); chk("byp_rd_b", rdb);
        expect_v(32'h11); chk("nobyp_rd_a", nb_rda);
        expect_v(32'h11); chk("nobyp_rd_b", nb_rdb);
        tick();
        drive(1'b0, 2'b00, 5'd7, '0, '0, '0);
        expect_v(32'h22); chk("nobyp_next_a", nb_rda);
        expect_v(32'h22); chk("nobyp_next_b", nb_rdb);

        // Previous-write registers
        drive(1'b1, 2'b00, 5'd9, 32'hA5A5_0000, '0, '0);
        tick();
        drive(1'b0, 2'b01, 5'd12, 32'h0BAD_0BAD, 32'h0BAD_0BAD, '0);
        expect_v(32'd1);          chk("prev_valid_n1", {31'd0, prev_valid});
        expect_v(32'd9);          chk("prev_dest_n1", {27'd0, prev_dest});
        expect_v(32'hA5A5_0000);  chk("prev_data_n1", prev_data);
        tick();
        expect_v(32'd0);          chk("prev_valid_n2", {31'd0, prev_valid});
        expect_v(32'd9);          chk("prev_dest_n2", {27'd0, prev_dest});
        expect_v(32'hA5A5_0000);  chk("prev_data_n2", prev_data);

        // Counter preload through a real flop update, then saturation
        force dut.write_count_d = 32'hFFFF_FFFE;
        tick();
        release dut.write_count_d;
        expect_v(32'hFFFF_FFFE); chk("sat_preload", cnt);
        ra = 5'd4;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'b00, 5'd4, 32'h44 + 32'(k), '0, '0);
            tick();
            we = 1'b0; #1;
            expect_v(32'hFFFF_FFFF); chk($sformatf("sat_count%0d", k), cnt);
        end
        expect_v(32'h46); chk("sat_r4", rda);

        // Mid-stream reset with a pending write to r4
        rst = 1'b1;
        drive(1'b1, 2'b00, 5'd4, 32'h0000_4444, '0, '0);
        expect_v(32'd0); chk("mid_rst_fwd_valid", {31'd0, fwd_valid});
        tick();
        rst = 1'b0;
        drive(1'b0, 2'b00, 5'd4, '0, '0, '0);
        expect_v(32'd0); chk("mid_rst_r4", rda);
        expect_v(32'd0); chk("mid_rst_count", cnt);
        expect_v(32'd0); chk("mid_rst_prev_valid", {31'd0, prev_valid});
        expect_v(32'd0); chk("mid_rst_prev_data", prev_data);

        // Cold-start write after reset
        drive(1'b1, 2'b11, 5'd4, '0, '0, 16'h7FFF);
        tick();
        we = 1'b0; #1;
        expect_v(32'h0000_7FFF); chk("post_rst_r4", rda);
        expect_v(32'd1);         chk("post_rst_count", cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-stage consumer of the MEM/WB pipeline register outputs. Each cycle it selects the writeback value (ALU result, memory data, or an immediate form) and commits it to a 32-entry architectural register file. It serves two combinational read ports to decode with same-cycle write-through bypass. It also exports current and previous-cycle writeback information for the forwarding unit.

Parameters:
DATA_W, 32, register and datapath width
ADDR_W, 5, register index width
NUM_REGS, 32, number of architectural registers; 2**ADDR_W
BYPASS_EN, 1, 1 = read ports see the same-cycle write value; 0 = they see the stored value only

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
wb_in_RegSrc  in  2  writeback source select
wb_in_RegWrite  in  1  write enable from the pipeline
wb_in_ALUOut_EXEC  in  DATA_W  ALU result
wb_in_Mem_dataOut  in  DATA_W  load data
wb_in_write_reg_dest  in  ADDR_W  destination register index
wb_in_immediate  in  16  instruction immediate
rd_addr_a  in  ADDR_W  read port A index
rd_addr_b  in  ADDR_W  read port B index
rd_data_a  out  DATA_W  read port A data (combinational)
rd_data_b  out  DATA_W  read port B data (combinational)
wb_fwd_valid  out  1  current-cycle write is effective
wb_fwd_dest  out  ADDR_W  current-cycle destination
wb_fwd_data  out  DATA_W  current-cycle selected writeback data
wb_prev_valid  out  1  registered: last cycle's write was effective
wb_prev_dest  out  ADDR_W  registered destination of last cycle's write
wb_prev_data  out  DATA_W  registered data of last cycle's write
wb_write_count  out  32  registered count of effective writes, saturating

Behaviour:
- Clocking: single clock domain; reset is synchronous and active-high. Ports are clk and rst.
- Source select (combinational): 00 = ALUOut_EXEC; 01 = Mem_dataOut; 10 = {immediate, 16'h0000} (upper-immediate); 11 = sign-extended immediate.
- Effective write: eff = wb_in_RegWrite && (wb_in_write_reg_dest != 0) && !rst.
- wb_fwd_valid = eff. wb_fwd_dest = dest. wb_fwd_data = selected value. All three are combinational.
- Commit: on posedge with eff, regs[dest] <= selected value. Latency is 1 cycle to the stored state.
- Register 0: reads always return 0. Writes to register 0 are dropped and are not counted.
- Read ports: if addr == 0, output 0. Else if BYPASS_EN && eff && addr == dest, output the selected value (write-through). Else output regs[addr]. Both ports may hit the same register or bypass simultaneously.
- Previous-write registers: on posedge, wb_prev_* <= {eff, dest, selected value}. When eff = 0, wb_prev_dest and wb_prev_data hold their prior values and wb_prev_valid = 0.
- Counter: wb_write_count increments on each eff cycle. It saturates at 32'hFFFF_FFFF with no wrap.
- Reset (synchronous, active-high) clears regs[1..31] to 0, wb_prev_valid/dest/data to 0, and wb_write_count to 0.
- A write presented in a reset cycle is discarded. Forwarding outputs are forced invalid in that cycle.
- Reset asserted mid-stream: the first cycle after deassertion behaves as cold start.
- X-safety: an undefined RegSrc is impossible, since all 4 codes are defined. RegWrite = 0 ignores the data inputs entirely.

Decomposition:
- Shared package (cpu_pkg): DATA_W, ADDR_W, NUM_REGS, and RegSrc encodings REGSRC_ALU=2'b00, REGSRC_MEM=2'b01, REGSRC_LUI=2'b10, REGSRC_SEXT=2'b11. The MEM/WB register and the control unit use the same encodings.
- One natural sub-module: wb_src_mux. It is combinational and performs source select plus immediate forming. It is reused by the forwarding unit. The storage array, read logic, prev registers and counter stay in wb_regfile.

Test Plan:
- Reset then read all: rst=1 for 2 cycles with RegWrite=1, dest=5 -> after release, rd_data_a/b = 0 for every index, wb_write_count=0, wb_prev_valid=0.
- Source select: in four consecutive cycles write dest=3, ALU=32'h1234_5678 (00), Mem=32'hDEAD_BEEF (01), imm=16'h8001 (10), imm=16'h8001 (11). Read r3 after each -> 1234_5678, DEAD_BEEF, 8001_0000, FFFF_8001; count=4.
- R0 protection: RegWrite=1, dest=0, ALU=32'hFFFF_FFFF -> rd_data_a(addr 0)=0, wb_fwd_valid=0, count unchanged, wb_prev_valid=0 next cycle.
- Bypass: r7=32'h11 stored; the same cycle writes r7=32'h22 with rd_addr_a=rd_addr_b=7 -> both read 32'h22 combinationally. With BYPASS_EN=0 both read 32'h11; next cycle both read 32'h22.
- Prev-forward: cycle N writes r9=32'hA5A5_0000; cycle N+1 RegWrite=0 -> in N+1 wb_prev_valid=1, dest=9, data=A5A5_0000. In N+2 wb_prev_valid=0 with dest/data held.
- Mid-op reset and saturation: preload the count to FFFF_FFFE via a force hook, do 3 writes -> count=FFFF_FFFF. Then rst one cycle during RegWrite=1, dest=4 -> r4=0, count=0.
